// File: rtl/constraint_sample_generator.sv
// Rejection sampler feeding a combinational constraint checker.
// Emits accepted candidate assignments over a valid/ready stream.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, req_count     request pulse and number of solutions
//   abort                synchronous return to IDLE
//   cand, cand_valid     candidate driven into the checker
//   chk_sat              checker satisfaction bit
//   sol_data, sol_valid  accepted solution stream
//   sol_ready            consumer handshake
//   busy, done, fail     status; done/fail are one-cycle pulses
//   total_tries          saturating count of evaluated candidates
module constraint_sample_generator #(
    parameter int          VAR_W     = 256,
    parameter logic [63:0] SEED      = 64'h1,
    parameter int          CHECK_LAT = 1,
    parameter int          MAX_TRIES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      req_count,
    input  logic             abort,
    output logic [VAR_W-1:0] cand,
    output logic             cand_valid,
    input  logic             chk_sat,
    output logic [VAR_W-1:0] sol_data,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [31:0]      total_tries
);

    localparam int NCH   = (VAR_W + 63) / 64;
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [63:0]      SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam logic [63:0]      TAPS     = 64'hD800000000000000;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);
    localparam logic [3:0]       LAT_LAST = 4'(CHECK_LAT);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT,
        OUT
    } state_t;

    state_t             state;
    logic [63:0]        lfsr;
    logic [64*NCH-1:0]  cand_full;
    logic [CH_W-1:0]    chunk;
    logic [3:0]         lat_cnt;
    logic [TRY_W-1:0]   try_cnt;
    logic [15:0]        remaining;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Top chunk may be wider than VAR_W; the excess high bits are dropped.
    assign cand = cand_full[VAR_W-1:0];
    assign busy = (state != IDLE);

    // Datapath: the LFSR advances on every FILL cycle, including one
    // that is being aborted, so an abort never rewinds the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= SEED_EFF;
            cand_full <= '0;
        end else if (state == FILL) begin
            cand_full[{chunk, 6'b0} +: 64] <= lfsr;
            lfsr                           <= lfsr_next(lfsr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            chunk       <= '0;
            lat_cnt     <= '0;
            try_cnt     <= '0;
            remaining   <= '0;
            cand_valid  <= 1'b0;
            sol_valid   <= 1'b0;
            sol_data    <= '0;
            done        <= 1'b0;
            fail        <= 1'b0;
            total_tries <= '0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            if (abort) begin
                state      <= IDLE;
                chunk      <= '0;
                lat_cnt    <= '0;
                try_cnt    <= '0;
                remaining  <= '0;
                cand_valid <= 1'b0;
                sol_valid  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (req_count == 16'd0) begin
                                done <= 1'b1;
                            end else begin
                                remaining <= req_count;
                                try_cnt   <= '0;
                                chunk     <= '0;
                                state     <= FILL;
                            end
                        end
                    end
                    FILL: begin
                        if (chunk == LAST_CH) begin
                            chunk      <= '0;
                            lat_cnt    <= '0;
                            cand_valid <= 1'b1;
                            state      <= WAIT;
                        end else begin
                            chunk <= chunk + 1'b1;
                        end
                    end
                    WAIT: begin
                        // chk_sat only matters on the final latency cycle.
                        if (lat_cnt == LAT_LAST) begin
                            cand_valid <= 1'b0;
                            lat_cnt    <= '0;
                            if (total_tries != 32'hFFFF_FFFF)
                                total_tries <= total_tries + 1'b1;
                            if (chk_sat) begin
                                sol_data  <= cand;
                                sol_valid <= 1'b1;
                                state     <= OUT;
                            end else if (try_cnt == TRY_LAST) begin
                                done      <= 1'b1;
                                fail      <= 1'b1;
                                try_cnt   <= '0;
                                remaining <= '0;
                                state     <= IDLE;
                            end else begin
                                try_cnt <= try_cnt + 1'b1;
                                state   <= FILL;
                            end
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    OUT: begin
                        if (sol_ready) begin
                            sol_valid <= 1'b0;
                            try_cnt   <= '0;
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state <= FILL;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_constraint_sample_generator.sv
// Self-checking bench for constraint_sample_generator.
// Directed table rows, abort/reset sequences, random requests.
module tb_constraint_sample_generator;

    localparam int VW = 256;
    localparam int MT = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [15:0]   req_count;
    logic          abort;
    logic [VW-1:0] cand;
    logic          cand_valid;
    logic          chk_sat;
    logic [VW-1:0] sol_data;
    logic          sol_valid;
    logic          sol_ready;
    logic          busy;
    logic          done;
    logic          fail;
    logic [31:0]   total_tries;

    constraint_sample_generator #(
        .VAR_W    (VW),
        .SEED     (64'h1),
        .CHECK_LAT(1),
        .MAX_TRIES(MT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .req_count  (req_count),
        .abort      (abort),
        .cand       (cand),
        .cand_valid (cand_valid),
        .chk_sat    (chk_sat),
        .sol_data   (sol_data),
        .sol_valid  (sol_valid),
        .sol_ready  (sol_ready),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .total_tries(total_tries)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: the LFSR output stream as a flat array, and a read
    // pointer into it. Each candidate consumes four consecutive words.
    logic [63:0]   seq [0:4095];
    int            m_pos;
    int unsigned   m_total;
    logic [VW-1:0] last_sol;
    logic [VW-1:0] exp1;
    logic [VW-1:0] sq [$];

    typedef struct {
        logic [15:0] req;
        logic        sat;
        int          stall;
        int          exp_sv;
        int          exp_done;
        logic        exp_fail;
        int          exp_hs;
        int          exp_tries;
        logic        exp_busy;
    } row_t;

    row_t rows [4];

    task automatic check(input string name, input logic [VW-1:0] act,
                         input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] cand_at(input int p);
        logic [VW-1:0] c;
        c = '0;
        for (int i = 0; i < 4; i++)
            c[64*i +: 64] = seq[p+i];
        return c;
    endfunction

    task automatic run_row(input row_t r);
        int            cyc, done_cnt, done_cyc, first_sv, hs, st;
        logic          fail_at_done, busy_seen, busy_at_done;
        logic [VW-1:0] held;
        logic [VW-1:0] vals [$];
        cyc = 0; done_cnt = 0; done_cyc = -1; first_sv = -1;
        hs = 0; st = 0; fail_at_done = 1'b0;
        busy_seen = 1'b0; busy_at_done = 1'b1; held = '0;
        chk_sat   = r.sat;
        req_count = r.req;
        sol_ready = 1'b0;
        start     = 1'b1;
        while (cyc < 200 && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (sol_valid && first_sv < 0) first_sv = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    fail_at_done = fail;
                    busy_at_done = busy;
                end
            end
            if (sol_valid) begin
                if (st < r.stall) begin
                    if (st > 0) check("stall_hold", sol_data, held);
                    held      = sol_data;
                    sol_ready = 1'b0;
                    st++;
                end else begin
                    check("sol_value", sol_data, cand_at(m_pos));
                    m_pos += 4;
                    hs++;
                    vals.push_back(sol_data);
                    last_sol  = sol_data;
                    sol_ready = 1'b1;
                    st        = 0;
                end
            end else begin
                sol_ready = 1'b0;
            end
        end
        sol_ready = 1'b0;
        m_pos   += 4 * (r.exp_tries - hs);
        m_total += r.exp_tries;
        check("done_count", done_cnt, 1);
        check("done_cycle", done_cyc, r.exp_done);
        check("fail_at_done", fail_at_done, r.exp_fail);
        check("busy_at_done", busy_at_done, 1'b0);
        check("first_sol_cycle", first_sv, r.exp_sv);
        check("handshakes", hs, r.exp_hs);
        check("busy_seen", busy_seen, r.exp_busy);
        check("total_tries", total_tries, m_total);
        for (int i = 0; i < vals.size(); i++)
            for (int j = i + 1; j < vals.size(); j++)
                check("distinct", vals[i] != vals[j], 1'b1);
    endtask

    task automatic run_random(input int n);
        int            cyc, wcyc, tries, got;
        logic          dec, finished;
        logic [VW-1:0] cur;
        cyc = 0; wcyc = 0; tries = 0; got = 0;
        dec = 1'b0; finished = 1'b0; cur = '0;
        sq.delete();
        req_count = 16'(n);
        chk_sat   = 1'($urandom);
        sol_ready = 1'($urandom);
        start     = 1'b1;
        while (!finished && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (sol_valid) begin
                check("rand_sol_pending", sq.size() > 0, 1'b1);
                if (sq.size() > 0) check("rand_sol", sol_data, sq[0]);
                sol_ready = 1'($urandom);
                if (sol_ready && sq.size() > 0) begin
                    void'(sq.pop_front());
                    got++;
                end
            end else begin
                sol_ready = 1'($urandom);
            end
            if (cand_valid) begin
                wcyc++;
                if (wcyc == 1) begin
                    cur = cand_at(m_pos);
                    m_pos += 4;
                    check("rand_cand", cand, cur);
                    dec     = ($urandom_range(0, 9) < 6);
                    chk_sat = !dec;
                end else begin
                    chk_sat = dec;
                    m_total++;
                    if (dec) begin
                        sq.push_back(cur);
                        tries = 0;
                    end else begin
                        tries++;
                    end
                end
            end else begin
                wcyc    = 0;
                chk_sat = 1'($urandom);
            end
            if (done) begin
                finished = 1'b1;
                check("rand_fail", fail, tries == MT);
                check("rand_busy_done", busy, 1'b0);
                if (!fail) check("rand_got", got, n);
            end
        end
        check("rand_finished", finished, 1'b1);
        sol_ready = 1'b0;
    endtask

    initial begin
        int   k;
        logic bad;

        seq[0] = 64'h1;
        for (int i = 1; i < 4096; i++)
            seq[i] = seq[i-1][0] ? ((seq[i-1] >> 1) ^ 64'hD800000000000000)
                                 : (seq[i-1] >> 1);
        m_pos   = 0;
        m_total = 0;
        exp1 = {64'h3600000000000000, 64'h6C00000000000000,
                64'hD800000000000000, 64'h1};

        rows[0] = '{16'd1, 1'b1, 0,  7,  8,  1'b0, 1, 1, 1'b1};
        rows[1] = '{16'd2, 1'b0, 0,  -1, 31, 1'b1, 0, 5, 1'b1};
        rows[2] = '{16'd3, 1'b1, 10, 7,  52, 1'b0, 3, 3, 1'b1};
        rows[3] = '{16'd0, 1'b1, 0,  -1, 1,  1'b0, 0, 0, 1'b0};

        rst_n = 1'b0; start = 1'b0; req_count = '0; abort = 1'b0;
        chk_sat = 1'b0; sol_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cand", cand, '0);
        check("rst_cand_valid", cand_valid, 1'b0);
        check("rst_sol_data", sol_data, '0);
        check("rst_sol_valid", sol_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", {done, fail}, 2'b00);
        check("rst_tries", total_tries, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run_row(rows[i]);
            if (i == 0) check("first_solution", last_sol, exp1);
        end

        // Abort during the second FILL cycle; start+abort in IDLE ignored.
        req_count = 16'd1; chk_sat = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_cand_valid", cand_valid, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done || fail || busy || sol_valid) bad = 1'b1;
            @(negedge clk);
        end
        check("abort_quiet", bad, 1'b0);
        m_pos += 2;
        run_row(rows[0]);

        // Reset while in WAIT.
        req_count = 16'd1; chk_sat = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 5) begin
            @(negedge clk);
            k++;
        end
        check("wait_cand_valid", cand_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cand_valid", cand_valid, 1'b0);
        check("mid_rst_cand", cand, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_tries", total_tries, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pos = 0; m_total = 0;
        @(negedge clk);
        run_row(rows[0]);
        check("post_rst_solution", last_sol, exp1);

        // Random back-to-back requests.
        for (int i = 0; i < 8; i++)
            run_random($urandom_range(1, 3));
        @(negedge clk);
        check("final_tries", total_tries, m_total);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
